// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and BTB entry/counter types for the fetch front end
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int BTB_ENTRIES = 64;
   // Tag field sized for the smallest legal table (4 entries); larger tables keep the upper bits zero
   localparam int BTB_TAG_W = XLEN - 4;
   typedef logic [1:0] bpred_ctr_t;
   localparam bpred_ctr_t CTR_WEAK_T = 2'b10;
   localparam bpred_ctr_t CTR_STRONG_T = 2'b11;
   typedef struct packed {
      logic valid;
      logic [BTB_TAG_W-1:0] tag;
      logic [XLEN-1:0] target;
      logic is_jump;
      bpred_ctr_t ctr;
   } btb_entry_t;
endpackage

// File: rtl/btb_table.sv
// btb_table: flop array of BTB entries, async lookup/update reads, sync write, sync valid-clear on reset
module btb_table
   import riscv_pkg::*;
#(
   parameter int ENTRIES = BTB_ENTRIES,
   localparam int IDX_W = $clog2(ENTRIES)
) (
   input  logic clk,
   input  logic reset,
   input  logic [IDX_W-1:0] lk_idx,
   output btb_entry_t lk_entry,
   input  logic [IDX_W-1:0] up_idx,
   output btb_entry_t up_entry,
   input  logic wr_en,
   input  btb_entry_t wr_entry
);
   btb_entry_t mem [ENTRIES];
   assign lk_entry = mem[lk_idx];
   assign up_entry = mem[up_idx];
   always_ff @(posedge clk)
      if (reset)
         for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
      else if (wr_en)
         mem[up_idx] <= wr_entry;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB + 2-bit counters; BPRED_PERF_EN adds update/mispredict counters
module branch_predictor
   import riscv_pkg::*;
#(
   parameter int ENTRIES = BTB_ENTRIES
) (
   input  logic clk,
   input  logic reset,
   input  logic fetch_valid,
   input  logic [XLEN-1:0] fetch_pc,
   output logic predict_taken,
   output logic [XLEN-1:0] predict_target,
   input  logic upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic upd_is_branch,
   input  logic upd_is_jump,
   input  logic upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic upd_mispredict
`ifdef BPRED_PERF_EN
   ,
   output logic [31:0] perf_updates,
   output logic [31:0] perf_mispredicts
`endif
);
   localparam int IDX_W = $clog2(ENTRIES);
   logic [IDX_W-1:0] f_idx, u_idx;
   logic [BTB_TAG_W-1:0] f_tag, u_tag;
   btb_entry_t f_e, u_e, wr_entry;
   logic f_hit, u_hit, is_br, wr_en;
   bpred_ctr_t ctr_nxt;
   assign f_idx = IDX_W'(fetch_pc >> 2);
   assign u_idx = IDX_W'(upd_pc >> 2);
   assign f_tag = BTB_TAG_W'(fetch_pc >> (IDX_W + 2));
   assign u_tag = BTB_TAG_W'(upd_pc >> (IDX_W + 2));
   btb_table #(.ENTRIES(ENTRIES)) u_table (
      .clk(clk),
      .reset(reset),
      .lk_idx(f_idx),
      .lk_entry(f_e),
      .up_idx(u_idx),
      .up_entry(u_e),
      .wr_en(wr_en),
      .wr_entry(wr_entry)
   );
   assign f_hit = f_e.valid && (f_e.tag == f_tag);
   assign u_hit = u_e.valid && (u_e.tag == u_tag);
   assign predict_taken = fetch_valid & f_hit & (f_e.is_jump | f_e.ctr[1]);
   assign predict_target = f_hit ? f_e.target : '0;
   assign is_br = upd_is_branch & ~upd_is_jump;
   assign ctr_nxt = upd_taken ? ((u_e.ctr == CTR_STRONG_T) ? CTR_STRONG_T : u_e.ctr + 2'd1)
                              : ((u_e.ctr == 2'b00) ? 2'b00 : u_e.ctr - 2'd1);
   // Not-taken branch misses allocate nothing; flagless hits are aliases and get invalidated
   assign wr_en = upd_valid & ~reset & (upd_is_jump | (is_br & (u_hit | upd_taken)) | (~upd_is_branch & u_hit));
   assign wr_entry = '{
      valid: upd_is_branch | upd_is_jump,
      tag: u_tag,
      target: (is_br & ~upd_taken) ? u_e.target : upd_target,
      is_jump: upd_is_jump,
      ctr: upd_is_jump ? CTR_STRONG_T : (u_hit ? ctr_nxt : CTR_WEAK_T)
   };
`ifdef BPRED_PERF_EN
   always_ff @(posedge clk)
      if (reset) begin
         perf_updates <= '0;
         perf_mispredicts <= '0;
      end else if (upd_valid & (upd_is_branch | upd_is_jump)) begin
         perf_updates <= perf_updates + 32'd1;
         if (upd_mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
      end
`else
   logic unused_mispredict;
   assign unused_mispredict = upd_mispredict;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor; define BPRED_PERF_EN to cover perf counters
module tb_branch_predictor;
   import riscv_pkg::*;
   logic clk = 1'b0, reset = 1'b1;
   logic fetch_valid = 1'b0, upd_valid = 1'b0, upd_is_branch = 1'b0, upd_is_jump = 1'b0;
   logic upd_taken = 1'b0, upd_mispredict = 1'b0, predict_taken;
   logic [31:0] fetch_pc = '0, upd_pc = '0, upd_target = '0, predict_target;
`ifdef BPRED_PERF_EN
   logic [31:0] perf_updates, perf_mispredicts;
`endif
   int checks = 0, failures = 0;
   logic [32:0] exp_q[$];

   typedef struct packed {
      logic fv;
      logic [31:0] fpc;
      logic uv;
      logic [31:0] upc;
      logic ub;
      logic uj;
      logic ut;
      logic [31:0] utgt;
      logic um;
      logic [32:0] exp;
   } row_t;

   branch_predictor dut (
      .clk(clk),
      .reset(reset),
      .fetch_valid(fetch_valid),
      .fetch_pc(fetch_pc),
      .predict_taken(predict_taken),
      .predict_target(predict_target),
      .upd_valid(upd_valid),
      .upd_pc(upd_pc),
      .upd_is_branch(upd_is_branch),
      .upd_is_jump(upd_is_jump),
      .upd_taken(upd_taken),
      .upd_target(upd_target),
      .upd_mispredict(upd_mispredict)
`ifdef BPRED_PERF_EN
      ,
      .perf_updates(perf_updates),
      .perf_mispredicts(perf_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic drive(input row_t r);
      @(negedge clk);
      fetch_valid = r.fv;
      fetch_pc = r.fpc;
      upd_valid = r.uv;
      upd_pc = r.upc;
      upd_is_branch = r.ub;
      upd_is_jump = r.uj;
      upd_taken = r.ut;
      upd_target = r.utgt;
      upd_mispredict = r.um;
   endtask

   task automatic test_reset();
      row_t rows[2] = '{
         '{1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, {1'b0, 32'h0}},
         '{1'b1, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, {1'b0, 32'h0}}
      };
      logic [32:0] e;
      reset = 1'b1;
      drive('{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 33'h0});
      drive('{1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 33'h0});
      for (int i = 0; i < 2; i++) begin
         drive(rows[i]);
         reset = 1'b0;
         exp_q.push_back(rows[i].exp);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({predict_taken, predict_target} !== e) begin
            failures++;
            $display("FAIL reset[%0d]: got taken=%0b target=%h want taken=%0b target=%h", i, predict_taken, predict_target, e[32], e[31:0]);
         end
      end
   endtask

   task automatic test_learn();
      row_t rows[2] = '{
         '{1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, {1'b0, 32'h0}},
         '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, {1'b1, 32'h200}}
      };
      logic [32:0] e;
      for (int i = 0; i < 2; i++) begin
         drive(rows[i]);
         exp_q.push_back(rows[i].exp);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({predict_taken, predict_target} !== e) begin
            failures++;
            $display("FAIL learn[%0d]: got taken=%0b target=%h want taken=%0b target=%h", i, predict_taken, predict_target, e[32], e[31:0]);
         end
      end
   endtask

   // Entry 0x100 starts at ctr=2; op 1=taken, 2=not-taken, 0=no update; last row has fetch_valid low
   task automatic test_counter();
      int op[13] = '{2, 2, 2, 1, 1, 0, 1, 1, 2, 0, 2, 0, 0};
      logic et[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      row_t r;
      logic [32:0] e;
      for (int i = 0; i < 13; i++) begin
         r = '{i != 12, 32'h100, op[i] != 0, 32'h100, 1'b1, 1'b0, op[i] == 1, 32'h200, 1'b0, {et[i], 32'h200}};
         drive(r);
         exp_q.push_back(r.exp);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({predict_taken, predict_target} !== e) begin
            failures++;
            $display("FAIL counter[%0d]: got taken=%0b target=%h want taken=%0b target=%h", i, predict_taken, predict_target, e[32], e[31:0]);
         end
      end
   endtask

   task automatic test_alias();
      row_t rows[12] = '{
         '{1'b0, 32'h40,  1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h80,   1'b0, {1'b0, 32'h0}},
         '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,    1'b0, {1'b0, 32'h0}},
         '{1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,    1'b0, {1'b1, 32'h80}},
         '{1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, {1'b1, 32'h80}},
         '{1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,    1'b0, {1'b0, 32'h0}},
         '{1'b1, 32'h104, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 32'h1000, 1'b0, {1'b0, 32'h0}},
         '{1'b1, 32'h104, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 32'h999,  1'b0, {1'b1, 32'h1000}},
         '{1'b1, 32'h108, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,    1'b0, {1'b0, 32'h0}},
         '{1'b1, 32'h104, 1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 32'h2000, 1'b0, {1'b1, 32'h1000}},
         '{1'b1, 32'h104, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b0, {1'b1, 32'h2000}},
         '{1'b1, 32'h104, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b0, {1'b1, 32'h2000}},
         '{1'b1, 32'h104, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,    1'b0, {1'b0, 32'h2000}}
      };
      logic [32:0] e;
      for (int i = 0; i < 12; i++) begin
         drive(rows[i]);
         exp_q.push_back(rows[i].exp);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({predict_taken, predict_target} !== e) begin
            failures++;
            $display("FAIL alias[%0d]: got taken=%0b target=%h want taken=%0b target=%h", i, predict_taken, predict_target, e[32], e[31:0]);
         end
      end
   endtask

   task automatic test_same_cycle();
      row_t rows[2] = '{
         '{1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0, {1'b0, 32'h0}},
         '{1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, {1'b1, 32'h400}}
      };
      logic [32:0] e;
      for (int i = 0; i < 2; i++) begin
         drive(rows[i]);
         exp_q.push_back(rows[i].exp);
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({predict_taken, predict_target} !== e) begin
            failures++;
            $display("FAIL same_cycle[%0d]: got taken=%0b target=%h want taken=%0b target=%h", i, predict_taken, predict_target, e[32], e[31:0]);
         end
      end
   endtask

`ifdef BPRED_PERF_EN
   task automatic test_perf();
      row_t idle = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 33'h0};
      row_t upds[4] = '{
         '{1'b0, 32'h0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 33'h0},
         '{1'b0, 32'h0, 1'b1, 32'h404, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 33'h0},
         '{1'b0, 32'h0, 1'b1, 32'h408, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 33'h0},
         '{1'b0, 32'h0, 1'b1, 32'h40c, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 33'h0}
      };
      logic [63:0] e;
      logic [63:0] exp_p[$];
      reset = 1'b1;
      drive(idle);
      for (int i = 0; i < 4; i++) begin
         drive(upds[i]);
         reset = 1'b0;
         if (i == 0) begin
            exp_p.push_back(64'h0);
            #1;
            e = exp_p.pop_front();
            checks++;
            if ({perf_updates, perf_mispredicts} !== e) begin
               failures++;
               $display("FAIL perf_reset: got %0d/%0d want %0d/%0d", perf_updates, perf_mispredicts, e[63:32], e[31:0]);
            end
         end
      end
      drive(idle);
      exp_p.push_back({32'd3, 32'd1});
      #1;
      e = exp_p.pop_front();
      checks++;
      if ({perf_updates, perf_mispredicts} !== e) begin
         failures++;
         $display("FAIL perf_count: got %0d/%0d want %0d/%0d", perf_updates, perf_mispredicts, e[63:32], e[31:0]);
      end
      reset = 1'b1;
      drive(idle);
      drive(idle);
      reset = 1'b0;
      exp_p.push_back(64'h0);
      #1;
      e = exp_p.pop_front();
      checks++;
      if ({perf_updates, perf_mispredicts} !== e) begin
         failures++;
         $display("FAIL perf_clear: got %0d/%0d want %0d/%0d", perf_updates, perf_mispredicts, e[63:32], e[31:0]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_learn();
      test_counter();
      test_alias();
      test_same_cycle();
`ifdef BPRED_PERF_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
